// File: rtl/rs_dec_stream_ctrl_if.sv
// Stream bundle between rs_dec_stream_ctrl and its upstream/downstream peers.
// Ports: in_* upstream byte stream (valid/ready), out_* framed output stream.
interface rs_dec_stream_ctrl_if;

   logic [7:0] in_data;
   logic       in_sop;
   logic       in_valid;
   logic       in_ready;

   logic [7:0] out_data;
   logic       out_sop;
   logic       out_eop;
   logic       out_valid;
   logic       out_ready;

   // master: environment side (drives upstream, consumes output)
   modport master (
      output in_data,
      output in_sop,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_sop,
      input  out_eop,
      input  out_valid,
      output out_ready
   );

   // slave: the controller itself
   modport slave (
      input  in_data,
      input  in_sop,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_sop,
      output out_eop,
      output out_valid,
      input  out_ready
   );

endinterface

// File: rtl/rs_dec_stream_ctrl.sv
// Stream controller around an RS(204,188) decoder: paces upstream bytes onto
// the decoder CE/input_byte protocol and frames decoder output into 188-byte
// packets (sop/eop) through a small registered FIFO.
// Ports: clk, reset (sync, active-high); strm (slave modport: in_* upstream,
//   out_* downstream); dec_ce/dec_byte to the decoder; dec_out/dec_ceo/
//   dec_valid from the decoder; sync_err/ovf_err sticky error flags.
// Option: define RS_CTRL_STATS_EN to add in_frames/out_frames counters.
module rs_dec_stream_ctrl #(
   parameter int CE_PERIOD = 8,
   parameter int OUT_DEPTH = 4,
   parameter int IN_LEN    = 204,
   parameter int OUT_LEN   = 188
) (
   input  logic                 clk,
   input  logic                 reset,
   rs_dec_stream_ctrl_if.slave  strm,
   output logic                 dec_ce,
   output logic [7:0]           dec_byte,
   input  logic [7:0]           dec_out,
   input  logic                 dec_ceo,
   input  logic                 dec_valid,
   output logic                 sync_err,
   output logic                 ovf_err
`ifdef RS_CTRL_STATS_EN
   ,
   output logic [15:0]          in_frames,
   output logic [15:0]          out_frames
`endif
);

   localparam int PW = $clog2(CE_PERIOD);
   localparam int AW = $clog2(OUT_DEPTH);
   localparam int LW = AW + 1;
   localparam int IW = $clog2(IN_LEN);
   localparam int OW = $clog2(OUT_LEN);

   localparam logic [PW-1:0] PACE_LD  = PW'(CE_PERIOD - 1);
   localparam logic [LW-1:0] LVL_HI   = LW'(OUT_DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(OUT_DEPTH);
   localparam logic [IW-1:0] IN_LAST  = IW'(IN_LEN - 1);
   localparam logic [OW-1:0] OUT_LAST = OW'(OUT_LEN - 1);

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   // run keeps in_ready low while reset is applied without giving
   // in_ready a combinational path from the reset pin.
   logic          run;
   logic [PW-1:0] pace_cnt;
   logic [IW-1:0] in_cnt;
   logic [OW-1:0] out_cnt;

   // FIFO entry: {byte, sop, eop}
   logic [9:0]    mem [OUT_DEPTH];
   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;

   // ---------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------
   logic [LW-1:0] level;
   logic          full;
   logic          in_rdy;
   logic          accept;
   logic          realign;
   logic          frame_end;
   logic          cap;
   logic          out_vld;
   logic          pop;
   logic          push;
   logic [9:0]    head;

   always_comb begin
      level     = wr_ptr - rd_ptr;
      full      = (level == LVL_FULL);
      // One slot of headroom is reserved so a decoder byte that is
      // already in flight can still be stored.
      in_rdy    = run && (pace_cnt == '0) && (level < LVL_HI);
      accept    = strm.in_valid && in_rdy;
      realign   = accept && strm.in_sop && (in_cnt != '0);
      frame_end = accept && !realign && (in_cnt == IN_LAST);
      cap       = dec_valid && dec_ceo;
      out_vld   = (level != '0);
      pop       = out_vld && strm.out_ready;
      // A pop in the same cycle frees the slot the push needs.
      push      = cap && (!full || pop);
      head      = mem[rd_ptr[AW-1:0]];
   end

   assign strm.in_ready  = in_rdy;
   assign strm.out_valid = out_vld;
   assign strm.out_data  = head[9:2];
   assign strm.out_sop   = head[1];
   assign strm.out_eop   = head[0];

   // ---------------------------------------------------------------
   // Input side: pacer, decoder drive, codeword counter
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         run      <= 1'b0;
         pace_cnt <= '0;
         in_cnt   <= '0;
         dec_ce   <= 1'b0;
         dec_byte <= '0;
         sync_err <= 1'b0;
      end else begin
         run    <= 1'b1;
         dec_ce <= accept;
         if (accept) begin
            pace_cnt <= PACE_LD;
            dec_byte <= strm.in_data;
            if (realign) begin
               // the sop byte is byte 0 of a new codeword
               sync_err <= 1'b1;
               in_cnt   <= IW'(1);
            end else if (in_cnt == IN_LAST) begin
               in_cnt <= '0;
            end else begin
               in_cnt <= in_cnt + 1'b1;
            end
         end else if (pace_cnt != '0) begin
            pace_cnt <= pace_cnt - 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Output side: capture, framing, FIFO
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         out_cnt <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ovf_err <= 1'b0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (cap) begin
            // framing advances even for a dropped byte
            if (out_cnt == OUT_LAST) begin
               out_cnt <= '0;
            end else begin
               out_cnt <= out_cnt + 1'b1;
            end
            if (!push) begin
               ovf_err <= 1'b1;
            end
         end
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= {dec_out,
                                    out_cnt == '0,
                                    out_cnt == OUT_LAST};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

`ifdef RS_CTRL_STATS_EN
   // ---------------------------------------------------------------
   // Frame statistics (wrap naturally at 16 bits)
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         in_frames  <= '0;
         out_frames <= '0;
      end else begin
         if (frame_end) begin
            in_frames <= in_frames + 1'b1;
         end
         if (pop && head[0]) begin
            out_frames <= out_frames + 1'b1;
         end
      end
   end
`else
   logic unused_stats;
   assign unused_stats = frame_end;
`endif

endmodule
